alu_mp_sequencer: RTL and testbench

- Multi-precision arithmetic sequencer. It drives the 16-bit ALU port (operands, 4-bit op code, carry-in) and consumes the ALU's Z and carry-out.
- It performs WORDS×16-bit ADD, SUB, EQ and unsigned GT by issuing one ALU operation per cycle, chaining the carry between 16-bit words.
- It sits between the datapath control and the ALU.
- The ALU is purely combinational, so its result is captured on the same edge the operation is issued.

---
 rtl/alu_mp_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_mp_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mp_sequencer.sv
// Multi-precision ADD/SUB/EQ/GT sequencer that issues one 16-bit ALU op per cycle.
// Ports: clk/resetN, start/op/opA/opB request, busy/done/res/flag result, alu* ALU drive/return.
module alu_mp_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [16*WORDS-1:0]  opA,
  input  logic [16*WORDS-1:0]  opB,
  output logic                 busy,
  output logic                 done,
  output logic [16*WORDS-1:0]  res,
  output logic                 flag,
  output logic [15:0]          aluA,
  output logic [15:0]          aluB,
  output logic [3:0]           aluC,
  output logic                 aluCarryIn,
  input  logic [15:0]          aluZ,
  input  logic                 aluCarryOut
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_NOTB = 3'd2;
  localparam logic [2:0] S_SUMB = 3'd3;
  localparam logic [2:0] S_CEQ  = 3'd4;
  localparam logic [2:0] S_GEQ  = 3'd5;
  localparam logic [2:0] S_GGT  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [3:0] C_NOP = 4'b0000;
  localparam logic [3:0] C_NOT = 4'b0011;
  localparam logic [3:0] C_ADD = 4'b0101;
  localparam logic [3:0] C_GT  = 4'b1101;
  localparam logic [3:0] C_EQ  = 4'b1110;

  logic [2:0]          state;
  logic [16*WORDS-1:0] a_q;
  logic [16*WORDS-1:0] b_q;
  logic [IW-1:0]       idx;
  logic                carry;
  logic [15:0]         nb;

  logic [15:0] a_w;
  logic [15:0] b_w;
  logic        c_next;
  logic        last;

  assign a_w  = a_q[int'(idx)*16 +: 16];
  assign b_w  = b_q[int'(idx)*16 +: 16];
  assign last = (idx == LAST);

  // ALU carry-out ignores carry-in; a carry-in that wraps the sum
  // to zero is the only other way to overflow.
  assign c_next = aluCarryOut | (aluCarryIn & (aluZ == 16'h0000));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    aluA       = 16'h0000;
    aluB       = 16'h0000;
    aluC       = C_NOP;
    aluCarryIn = 1'b0;
    case (state)
      S_ADD: begin
        aluA       = a_w;
        aluB       = b_w;
        aluC       = C_ADD;
        aluCarryIn = carry;
      end
      S_NOTB: begin
        aluA = a_w;
        aluB = b_w;
        aluC = C_NOT;
      end
      S_SUMB: begin
        aluA       = a_w;
        aluB       = nb;
        aluC       = C_ADD;
        aluCarryIn = carry;
      end
      S_CEQ, S_GEQ: begin
        aluA = a_w;
        aluB = b_w;
        aluC = C_EQ;
      end
      S_GGT: begin
        aluA = a_w;
        aluB = b_w;
        aluC = C_GT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      nb    <= 16'h0000;
      res   <= '0;
      flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= opA;
            b_q   <= opB;
            res   <= '0;
            flag  <= 1'b0;
            carry <= (op == 2'b01);
            idx   <= (op == 2'b11) ? LAST : '0;
            case (op)
              2'b00:   state <= S_ADD;
              2'b01:   state <= S_NOTB;
              2'b10:   state <= S_CEQ;
              default: state <= S_GEQ;
            endcase
          end
        end
        S_ADD: begin
          res[int'(idx)*16 +: 16] <= aluZ;
          carry <= c_next;
          if (last) begin
            flag  <= c_next;
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_NOTB: begin
          nb    <= aluZ;
          state <= S_SUMB;
        end
        S_SUMB: begin
          res[int'(idx)*16 +: 16] <= aluZ;
          carry <= c_next;
          if (last) begin
            flag  <= c_next;
            state <= S_DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_NOTB;
          end
        end
        S_CEQ: begin
          if (!aluZ[0]) begin
            flag  <= 1'b0;
            state <= S_DONE;
          end else if (last) begin
            flag  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_GEQ: begin
          if (!aluZ[0]) begin
            state <= S_GGT;
          end else if (idx == '0) begin
            flag  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        S_GGT: begin
          flag  <= aluZ[0];
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Self-checking bench for alu_mp_sequencer with a behavioural ALU and a
// 64-bit arithmetic reference model.
module tb_alu_mp_sequencer;

  localparam int W = 4;
  localparam int N = 16 * W;

  logic         clk = 1'b0;
  logic         resetN;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] opA;
  logic [N-1:0] opB;
  logic         busy;
  logic         done;
  logic [N-1:0] res;
  logic         flag;
  logic [15:0]  aluA;
  logic [15:0]  aluB;
  logic [3:0]   aluC;
  logic         aluCarryIn;
  logic [15:0]  aluZ;
  logic         aluCarryOut;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_mp_sequencer #(.WORDS(W)) dut (
    .clk(clk),
    .resetN(resetN),
    .start(start),
    .op(op),
    .opA(opA),
    .opB(opB),
    .busy(busy),
    .done(done),
    .res(res),
    .flag(flag),
    .aluA(aluA),
    .aluB(aluB),
    .aluC(aluC),
    .aluCarryIn(aluCarryIn),
    .aluZ(aluZ),
    .aluCarryOut(aluCarryOut)
  );

  // External combinational ALU: carry-out covers A+B only.
  always_comb begin
    logic [16:0] s;
    s           = {1'b0, aluA} + {1'b0, aluB};
    aluZ        = 16'h0000;
    aluCarryOut = 1'b0;
    case (aluC)
      4'b0000: aluZ = aluA;
      4'b0101: begin
        aluZ        = s[15:0] + {15'b0, aluCarryIn};
        aluCarryOut = s[16];
      end
      4'b0011: aluZ = ~aluB;
      4'b1110: aluZ = {15'b0, aluA == aluB};
      4'b1101: aluZ = {15'b0, aluA > aluB};
      default: aluZ = 16'h0000;
    endcase
  end

  function automatic logic [N-1:0] m_res(logic [1:0] o, logic [N-1:0] a, logic [N-1:0] b);
    case (o)
      2'b00:   return a + b;
      2'b01:   return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic logic m_flag(logic [1:0] o, logic [N-1:0] a, logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (o)
      2'b00:   return s[N];
      2'b01:   return a >= b;
      2'b10:   return a == b;
      default: return a > b;
    endcase
  endfunction

  function automatic int m_lat(logic [1:0] o, logic [N-1:0] a, logic [N-1:0] b);
    case (o)
      2'b00: return W + 1;
      2'b01: return 2 * W + 1;
      2'b10: begin
        for (int i = 0; i < W; i++)
          if (a[i*16 +: 16] != b[i*16 +: 16]) return i + 2;
        return W + 1;
      end
      default: begin
        for (int k = 0; k < W; k++)
          if (a[(W-1-k)*16 +: 16] != b[(W-1-k)*16 +: 16]) return k + 3;
        return W + 1;
      end
    endcase
  endfunction

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Entered and left on a falling edge. Operands are scrambled after
  // acceptance; spam keeps start high through the whole operation.
  task automatic do_op(input logic [1:0] o, input logic [N-1:0] a,
                       input logic [N-1:0] b, input bit spam,
                       output logic [N-1:0] r, output logic f,
                       output int lat, output bit ok);
    op    = o;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!spam) start = 1'b0;
    opA = rnd64();
    opB = rnd64();
    op  = 2'($urandom);
    lat = -1;
    ok  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!busy) ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    r = res;
    f = flag;
    @(negedge clk);
    start = 1'b0;
    if (done || busy) ok = 1'b0;
    if (res !== r || flag !== f) ok = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    opA    = '0;
    opB    = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, flag, res, aluA, aluB, aluC, aluCarryIn} !== '0)
      $display("FAIL reset: busy=%b done=%b flag=%b res=%h aluC=%h aluA=%h aluB=%h cin=%b, want all 0",
               busy, done, flag, res, aluC, aluA, aluB, aluCarryIn);
    else passed++;
    resetN = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || aluC !== 4'b0000)
      $display("FAIL idle: busy=%b aluC=%h, want 0/0", busy, aluC);
    else passed++;
  endtask

  task automatic test_directed();
    logic [1:0]   vo[12];
    logic [N-1:0] va[12];
    logic [N-1:0] vb[12];
    logic [N-1:0] r;
    logic         f;
    int           lat;
    bit           ok;
    vo[0]  = 2'b00; va[0]  = 64'hFFFF_FFFF_FFFF_FFFF; vb[0]  = 64'h1;
    vo[1]  = 2'b00; va[1]  = 64'h0000_FFFF_FFFF_0001; vb[1]  = 64'h0000_0000_0000_FFFF;
    vo[2]  = 2'b00; va[2]  = 64'h8000_0000_0000_0000; vb[2]  = 64'h8000_0000_0000_0000;
    vo[3]  = 2'b01; va[3]  = 64'h5;                   vb[3]  = 64'h7;
    vo[4]  = 2'b01; va[4]  = 64'h1234_0000_0000_0000; vb[4]  = 64'h1234_0000_0000_0000;
    vo[5]  = 2'b01; va[5]  = 64'h0001_0000_0000_0000; vb[5]  = 64'h1;
    vo[6]  = 2'b10; va[6]  = 64'h0001_0002_0003_0004; vb[6]  = 64'h0001_0002_0003_0004;
    vo[7]  = 2'b10; va[7]  = 64'h0001_0002_0003_0004; vb[7]  = 64'h0001_0002_0003_0005;
    vo[8]  = 2'b10; va[8]  = 64'h0001_0002_0003_0004; vb[8]  = 64'h0009_0002_0003_0004;
    vo[9]  = 2'b11; va[9]  = 64'h8000_0000_0000_0000; vb[9]  = 64'h7FFF_FFFF_FFFF_FFFF;
    vo[10] = 2'b11; va[10] = 64'hABCD_0000_0000_0001; vb[10] = 64'hABCD_0000_0000_0001;
    vo[11] = 2'b11; va[11] = 64'hABCD_0000_0000_0001; vb[11] = 64'hABCD_0000_0000_0002;
    for (int i = 0; i < 12; i++) begin
      do_op(vo[i], va[i], vb[i], 1'b0, r, f, lat, ok);
      total++;
      if (r !== m_res(vo[i], va[i], vb[i]) || f !== m_flag(vo[i], va[i], vb[i]))
        $display("FAIL dir%0d op=%0d: res=%h flag=%b, want res=%h flag=%b", i, vo[i],
                 r, f, m_res(vo[i], va[i], vb[i]), m_flag(vo[i], va[i], vb[i]));
      else passed++;
      total++;
      if (lat !== m_lat(vo[i], va[i], vb[i]) || !ok)
        $display("FAIL dir%0d timing: lat=%0d pulse_ok=%b, want lat=%0d pulse_ok=1", i,
                 lat, ok, m_lat(vo[i], va[i], vb[i]));
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] r;
    logic         f;
    int           lat;
    bit           ok;
    int           j;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = rnd64();
      b = rnd64();
      case ($urandom_range(2))
        0: b = a;
        1: begin
          b = a;
          j = $urandom_range(W - 1);
          b[j*16 +: 16] = 16'($urandom);
        end
        default: ;
      endcase
      do_op(o, a, b, 1'b0, r, f, lat, ok);
      total++;
      if (r !== m_res(o, a, b) || f !== m_flag(o, a, b) || lat !== m_lat(o, a, b) || !ok)
        $display("FAIL rnd%0d op=%0d a=%h b=%h: res=%h flag=%b lat=%0d ok=%b, want res=%h flag=%b lat=%0d",
                 i, o, a, b, r, f, lat, ok, m_res(o, a, b), m_flag(o, a, b), m_lat(o, a, b));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] r;
    logic         f;
    int           lat;
    bit           ok;
    a = rnd64();
    b = rnd64();
    do_op(2'b00, a, b, 1'b1, r, f, lat, ok);
    total++;
    if (r !== m_res(2'b00, a, b) || f !== m_flag(2'b00, a, b) || lat !== W + 1 || !ok)
      $display("FAIL spam_add: res=%h flag=%b lat=%0d ok=%b, want res=%h flag=%b lat=%0d",
               r, f, lat, ok, m_res(2'b00, a, b), m_flag(2'b00, a, b), W + 1);
    else passed++;
    a = rnd64();
    b = rnd64();
    do_op(2'b01, a, b, 1'b0, r, f, lat, ok);
    total++;
    if (r !== m_res(2'b01, a, b) || f !== m_flag(2'b01, a, b) || lat !== 2 * W + 1 || !ok)
      $display("FAIL b2b_sub: res=%h flag=%b lat=%0d ok=%b, want res=%h flag=%b lat=%0d",
               r, f, lat, ok, m_res(2'b01, a, b), m_flag(2'b01, a, b), 2 * W + 1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] r;
    logic         f;
    int           lat;
    bit           ok;
    bit           seen;
    op    = 2'b01;
    opA   = 64'h5;
    opB   = 64'h7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (res === '0 || busy !== 1'b1)
      $display("FAIL mid_sub_progress: res=%h busy=%b, want res!=0 busy=1", res, busy);
    else passed++;
    resetN = 1'b0;
    #1;
    total++;
    if ({busy, done, flag, res, aluC} !== '0)
      $display("FAIL mid_reset: busy=%b done=%b flag=%b res=%h aluC=%h, want all 0",
               busy, done, flag, res, aluC);
    else passed++;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    resetN = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    total++;
    if (seen)
      $display("FAIL mid_no_done: done/busy=1, want 0");
    else passed++;
    do_op(2'b01, 64'h5, 64'h7, 1'b0, r, f, lat, ok);
    total++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || f !== 1'b0 || lat !== 2 * W + 1 || !ok)
      $display("FAIL post_reset_sub: res=%h flag=%b lat=%0d ok=%b, want res=fffffffffffffffe flag=0 lat=%0d",
               r, f, lat, ok, 2 * W + 1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
